// File: rtl/fsync_pkg.sv
// Shared types and helpers for the serial frame synchronizer.
package fsync_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } fsync_state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_word_match.sv
// Sliding-window sync word detector; match reflects the window including the current bit x.
module sync_word_match
    import fsync_pkg::*;
#(
    parameter int               SYNC_W    = 4,
    parameter logic [SYNC_W-1:0] SYNC_WORD = 4'b0110
) (
    input  logic clk,
    input  logic reset,
    input  logic x,
    input  logic x_valid,
    output logic match
);

    localparam int FW = clog2(SYNC_W) + 1;
    localparam logic [FW-1:0] FILL_MAX = FW'(SYNC_W - 1);

    logic [SYNC_W-2:0] shreg;
    logic [FW-1:0]     fill;
    logic [SYNC_W-1:0] window;

    assign window = {shreg, x};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
            fill  <= '0;
        end else if (x_valid) begin
            shreg <= window[SYNC_W-2:0];
            if (fill != FILL_MAX) begin
                fill <= fill + 1'b1;
            end
        end
    end

    // Fill qualification keeps the cleared shift register from matching an all-zero word.
    assign match = (fill == FILL_MAX) && (window == SYNC_WORD);

endmodule

// File: rtl/frame_sync_ctrl.sv
// Frame synchronizer: hunts for the sync word, verifies its spacing, then tracks frames in lock.
//
// state  | meaning
// HUNT   | searching every valid bit for the sync word
// VERIFY | sync found; checking it repeats every FRAME_LEN bits
// LOCK   | framed; payload bits qualified, isolated sync misses tolerated
module frame_sync_ctrl
    import fsync_pkg::*;
#(
    parameter int                SYNC_W    = 4,
    parameter logic [SYNC_W-1:0] SYNC_WORD = 4'b0110,
    parameter int                FRAME_LEN = 8,
    parameter int                LOCK_CNT  = 3,
    parameter int                LOSS_CNT  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       x,
    input  logic       x_valid,
    output logic       lock,
    output logic       frame_start,
    output logic       sync_err,
    output logic       data_valid,
    output logic       data_out,
    output logic [1:0] state
);

    localparam int BW = clog2(FRAME_LEN);
    localparam int GW = clog2(LOCK_CNT + 1);
    localparam int MW = clog2(LOSS_CNT + 1);

    localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_LEN - 1);
    localparam logic [BW-1:0] PAY_LAST  = BW'(FRAME_LEN - SYNC_W - 1);
    localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_CNT);
    localparam logic [MW-1:0] MISS_DROP = MW'(LOSS_CNT);

    fsync_state_t  state_q, state_d;
    logic [BW-1:0] bitcnt_q, bitcnt_d;
    logic [GW-1:0] good_q, good_d;
    logic [MW-1:0] miss_q, miss_d;
    logic          frame_start_d, sync_err_d, data_valid_d, data_out_d;
    logic          match;
    logic          exp_sync;

    sync_word_match #(
        .SYNC_W    (SYNC_W),
        .SYNC_WORD (SYNC_WORD)
    ) u_match (
        .clk     (clk),
        .reset   (reset),
        .x       (x),
        .x_valid (x_valid),
        .match   (match)
    );

    assign exp_sync = (bitcnt_q == LAST_BIT);

    always_comb begin
        state_d       = state_q;
        bitcnt_d      = bitcnt_q;
        good_d        = good_q;
        miss_d        = miss_q;
        frame_start_d = 1'b0;
        sync_err_d    = 1'b0;
        data_valid_d  = 1'b0;
        data_out_d    = 1'b0;

        if (x_valid) begin
            bitcnt_d = exp_sync ? '0 : bitcnt_q + 1'b1;
            case (state_q)
                HUNT: begin
                    if (match) begin
                        state_d  = VERIFY;
                        good_d   = GW'(1);
                        bitcnt_d = '0;
                    end
                end
                VERIFY: begin
                    if (exp_sync) begin
                        if (match) begin
                            good_d = good_q + GW'(1);
                            if (good_q + GW'(1) == GOOD_LOCK) begin
                                state_d       = LOCK;
                                miss_d        = '0;
                                frame_start_d = 1'b1;
                            end
                        end else begin
                            state_d = HUNT;
                            good_d  = '0;
                        end
                    end
                end
                LOCK: begin
                    if (bitcnt_q <= PAY_LAST) begin
                        data_valid_d = 1'b1;
                        data_out_d   = x;
                    end
                    if (exp_sync) begin
                        if (match) begin
                            frame_start_d = 1'b1;
                            miss_d        = '0;
                        end else begin
                            sync_err_d = 1'b1;
                            if (miss_q + MW'(1) == MISS_DROP) begin
                                state_d = HUNT;
                                good_d  = '0;
                                miss_d  = '0;
                            end else begin
                                miss_d = miss_q + MW'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= HUNT;
            bitcnt_q    <= '0;
            good_q      <= '0;
            miss_q      <= '0;
            lock        <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
            data_valid  <= 1'b0;
            data_out    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            good_q      <= good_d;
            miss_q      <= miss_d;
            lock        <= (state_d == LOCK);
            frame_start <= frame_start_d;
            sync_err    <= sync_err_d;
            data_valid  <= data_valid_d;
            data_out    <= data_out_d;
        end
    end

    assign state = state_q;

endmodule
